// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ysyx_22050710_defines
// Desc     : Shared source IDs and grant FSM encodings for the SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22050710_defines;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Round-robin tie break: the master that did not win last time.
    function automatic logic rr_pick(input logic last_src);
        return ~last_src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_id_fifo
// Desc     : Small in-order FIFO of source IDs for issued-but-unanswered
//            requests; the head selects which master receives a response.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WD    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [WD-1:0] i_din,
    output logic [WD-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_WD-1:0] c_LAST_PTR  = c_PTR_WD'(DEPTH - 1);
    localparam logic [c_PTR_WD:0]   c_FULL_CNT  = (c_PTR_WD + 1)'(DEPTH);

    logic [WD-1:0]       r_mem [DEPTH];
    logic [c_PTR_WD-1:0] r_wr_ptr;
    logic [c_PTR_WD-1:0] r_rd_ptr;
    logic [c_PTR_WD:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_sram_arbiter
// Desc     : Two-master (inst/data) to one-slave SRAM-like arbiter with
//            round-robin grant, per-request lock and in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_sram_arbiter
    import ysyx_22050710_defines::*;
#(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_WMASK_WD = 8,
    parameter int SRAM_DATA_WD  = 64,
    parameter int OUTSTANDING   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     i_inst_req,
    input  logic                     i_inst_op,
    input  logic [1:0]               i_inst_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_inst_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_inst_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_inst_wdata,
    output logic                     o_inst_addr_ok,
    output logic                     o_inst_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_inst_rdata,

    input  logic                     i_data_req,
    input  logic                     i_data_op,
    input  logic [1:0]               i_data_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_data_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_data_wdata,
    output logic                     o_data_addr_ok,
    output logic                     o_data_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_data_rdata,

    output logic                     o_sram_req,
    output logic                     o_sram_op,
    output logic [1:0]               o_sram_size,
    output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
    output logic [SRAM_WMASK_WD-1:0] o_sram_wstrb,
    output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
    input  logic                     i_sram_addr_ok,
    input  logic                     i_sram_data_ok,
    input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata
);

    arb_state_e r_state;
    logic       r_owner;
    logic       r_rr_last;

    logic w_grant_valid;
    logic w_grant_id;
    logic w_addr_hs;
    logic w_rsp_valid;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_fifo_head;

    // Grant selection: LOCK pins the owner, IDLE arbitrates unless full.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = SRC_INST;
        if (r_state == ARB_LOCK) begin
            w_grant_valid = 1'b1;
            w_grant_id    = r_owner;
        end else if (!w_fifo_full) begin
            if (i_inst_req && i_data_req) begin
                w_grant_valid = 1'b1;
                w_grant_id    = rr_pick(r_rr_last);
            end else if (i_inst_req) begin
                w_grant_valid = 1'b1;
                w_grant_id    = SRC_INST;
            end else if (i_data_req) begin
                w_grant_valid = 1'b1;
                w_grant_id    = SRC_DATA;
            end
        end
    end

    always_comb begin
        o_sram_req   = 1'b0;
        o_sram_op    = 1'b0;
        o_sram_size  = '0;
        o_sram_addr  = '0;
        o_sram_wstrb = '0;
        o_sram_wdata = '0;
        if (w_grant_valid) begin
            if (w_grant_id == SRC_DATA) begin
                o_sram_req   = i_data_req;
                o_sram_op    = i_data_op;
                o_sram_size  = i_data_size;
                o_sram_addr  = i_data_addr;
                o_sram_wstrb = i_data_wstrb;
                o_sram_wdata = i_data_wdata;
            end else begin
                o_sram_req   = i_inst_req;
                o_sram_op    = i_inst_op;
                o_sram_size  = i_inst_size;
                o_sram_addr  = i_inst_addr;
                o_sram_wstrb = i_inst_wstrb;
                o_sram_wdata = i_inst_wdata;
            end
        end
    end

    assign w_addr_hs      = w_grant_valid & i_sram_addr_ok;
    assign o_inst_addr_ok = w_addr_hs & (w_grant_id == SRC_INST);
    assign o_data_addr_ok = w_addr_hs & (w_grant_id == SRC_DATA);

    // A response with nothing outstanding is spurious and is dropped here.
    assign w_rsp_valid    = i_sram_data_ok & ~w_fifo_empty;
    assign o_inst_data_ok = w_rsp_valid & (w_fifo_head == SRC_INST);
    assign o_data_data_ok = w_rsp_valid & (w_fifo_head == SRC_DATA);
    assign o_inst_rdata   = i_sram_rdata;
    assign o_data_rdata   = i_sram_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= SRC_INST;
            r_rr_last <= SRC_DATA;
        end else if (r_state == ARB_IDLE) begin
            if (w_grant_valid) begin
                if (i_sram_addr_ok) begin
                    r_rr_last <= w_grant_id;
                end else begin
                    r_state <= ARB_LOCK;
                    r_owner <= w_grant_id;
                end
            end
        end else begin
            if (i_sram_addr_ok) begin
                r_state   <= ARB_IDLE;
                r_rr_last <= r_owner;
            end
        end
    end

    ysyx_22050710_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WD    (1)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_addr_hs),
        .i_pop   (i_sram_data_ok),
        .i_din   (w_grant_id),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: doc/ysyx_22050710_sram_arbiter.md
# ysyx_22050710_sram_arbiter

Two-master, one-slave arbiter for the core's SRAM-like memory interface. It merges the instruction-fetch port (IF stage) and the load/store port (EX/MEM stages) onto a single SRAM-like slave port in front of the memory subsystem. It uses round-robin grant with a per-request lock, and tracks issued requests in order so each `data_ok`/`rdata` is routed back to the master that issued it.

## Interface
Parameters:
- `SRAM_ADDR_WD`, 32, address width
- `SRAM_WMASK_WD`, 8, write strobe width
- `SRAM_DATA_WD`, 64, data width
- `OUTSTANDING`, 4, maximum issued-but-unanswered requests; power of two, ≥2

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_inst_req`, `i_inst_op`  in  1 each  inst master request and op (1 = write)
- `i_inst_size`  in  2  inst master transfer size
- `i_inst_addr`  in  SRAM_ADDR_WD  inst master address
- `i_inst_wstrb`  in  SRAM_WMASK_WD  inst master write strobe
- `i_inst_wdata`  in  SRAM_DATA_WD  inst master write data
- `o_inst_addr_ok`, `o_inst_data_ok`  out  1 each  inst master handshakes
- `o_inst_rdata`  out  SRAM_DATA_WD  inst master read data
- `i_data_*` and `o_data_*`  same set as the inst master, for the data master
- `o_sram_req`, `o_sram_op`  out  1 each  slave request and op
- `o_sram_size`  out  2  slave transfer size
- `o_sram_addr`  out  SRAM_ADDR_WD  slave address
- `o_sram_wstrb`  out  SRAM_WMASK_WD  slave write strobe
- `o_sram_wdata`  out  SRAM_DATA_WD  slave write data
- `i_sram_addr_ok`, `i_sram_data_ok`  in  1 each  slave handshakes
- `i_sram_rdata`  in  SRAM_DATA_WD  slave read data

## Operation
- **Grant FSM**, two states: IDLE and LOCK.
  - In LOCK, an `owner` register holds the locked master: 0 = inst, 1 = data.
  - **IDLE:**
    - If `full`, grant nobody.
    - Otherwise, if exactly one master requests, grant it.
    - If both request, grant the one that was not granted last (`rr_last`).
    - Granted master's request fields drive `o_sram_*`, and `o_sram_req` = 1.
    - If `i_sram_addr_ok` is 1 in that cycle: the handshake completes, the FSM stays in IDLE, and `rr_last` updates to the granted master.
    - Otherwise: go to LOCK with `owner` = granted master.
  - **LOCK:**
    - `o_sram_*` driven from `owner`; other master ignored.
    - On `i_sram_addr_ok`: go to IDLE and set `rr_last` = `owner`.
    - The lock keeps the slave-side address and data stable while `req` is held.
    - LOCK holds even if `full` becomes true; that cannot happen, since LOCK is only entered when not full.
- **Handshake routing:**
  - `o_X_addr_ok = i_sram_addr_ok & grant_X`.
  - The non-granted master sees `addr_ok` = 0.
  - When nobody is granted, `o_sram_req` = 0 and the other `o_sram_*` fields are don't-care (drive 0).
- **Source-ID FIFO** (1-bit entries, depth `OUTSTANDING`):
  - Push the granted ID on each slave address handshake.
  - Pop on each `i_sram_data_ok`.
  - Head ID routes the response: `o_X_data_ok = i_sram_data_ok & ~empty & (head == X)`.
  - `o_X_rdata = i_sram_rdata` for both masters (qualified by `data_ok`).
- **Slave ordering:** the slave returns responses strictly in request order. Writes also produce `data_ok`.
- **Boundary rules:**
  - `full` (`count == OUTSTANDING`) blocks new grants in IDLE, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: `count` unchanged, and both pointers advance modulo `OUTSTANDING`.
  - `data_ok` while empty is spurious: ignored, no pop, both `o_X_data_ok` = 0.
  - A master dropping `req` in LOCK is a protocol violation. Behaviour: keep driving the owner's current inputs.

## Timing
- Request path is combinational, zero latency: master `req` to `o_sram_req` in the same cycle; `i_sram_addr_ok` to `o_X_addr_ok` in the same cycle.
- Response path is combinational from the FIFO head: `i_sram_data_ok` to `o_X_data_ok` in the same cycle.
- A request's `data_ok` may arrive no earlier than the cycle after its `addr_ok`.
- **Reset values:**
  - FSM = IDLE, `owner` = 0, `rr_last` = 1 (inst wins the first tie).
  - FIFO empty, `count` = 0.
  - All `o_*` = 0, given the master `req` inputs are 0 during reset.
- **Reset mid-operation:** in-flight IDs are discarded. Later slave `data_ok` is treated as spurious (dropped). The system resets the slave together with the arbiter.
- Throughput: one grant per cycle when the slave accepts every cycle and the FIFO is not full.

## Structure
- **Shared package (`ysyx_22050710_defines`):**
  - source-ID constants `SRC_INST` = 1'b0, `SRC_DATA` = 1'b1
  - FSM state encodings `ARB_IDLE`, `ARB_LOCK`
- **Sub-module `ysyx_22050710_id_fifo`:**
  - parameters `DEPTH`, `WD`
  - ports: push, pop, din, dout (head), full, empty
  - async active-high reset
- Arbiter top holds the FSM, `owner`, `rr_last`, and the output muxes.

## Test plan
- **Lone inst read:** inst `req` at `addr` 0x8000_0000; slave `addr_ok` in cycle 0, `data_ok` in cycle 2 with `rdata` 0x1234 → `o_inst_addr_ok` = 1 in cycle 0, `o_inst_data_ok` = 1 with 0x1234 in cycle 2, data master sees nothing.
- **Tie after reset:** both request in cycle 0, slave always ready → grants go inst, data, inst, data; responses route in that order.
- **Lock:**
  - inst granted, slave withholds `addr_ok` for 3 cycles while data requests.
  - Required: `o_sram_addr` stays equal to the inst address for all 3 cycles.
  - Data is granted in the cycle after inst's `addr_ok`.
- **Full:**
  - With `OUTSTANDING` = 4: issue 4 accepted data writes, no `data_ok`.
  - A 5th request gives `o_sram_req` = 0.
  - After one `data_ok`, the 5th is granted the next cycle.
- **Spurious response and reset:**
  - `data_ok` with the FIFO empty → both `o_X_data_ok` = 0.
  - Assert `i_rst` with 2 requests outstanding → FIFO empty; a subsequent `data_ok` is dropped.
